// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with a start/done handshake.
// Single-cycle logic ops, add/sub/slt; one-bit-per-cycle shifts and shift-add multiply.
module alu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       ALU_control,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned SW = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SLL = 4'b0011,
    OP_SRL = 4'b0100,
    OP_SRA = 4'b0101,
    OP_SUB = 4'b0110,
    OP_SLT = 4'b0111,
    OP_MUL = 4'b1000,
    OP_NOR = 4'b1100
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    MUL
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc;
  logic [SW-1:0]    cnt;
  logic [3:0]       op_reg;

  logic [3:0]       op;
  logic [SW-1:0]    amt;
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             add_ovf;
  logic             less;
  logic [WIDTH-1:0] imm_res;
  logic             imm_c;
  logic             imm_v;
  logic [WIDTH-1:0] acc_next;

  assign op   = ALU_control;
  assign amt  = src2[SW-1:0];
  assign zero = (result == '0);

  // One-bit shift step, direction and fill chosen by the shift opcode
  function automatic logic [WIDTH-1:0] shift1(input logic [3:0] k, input logic [WIDTH-1:0] v);
    case (k)
      OP_SLL:  shift1 = v << 1;
      OP_SRL:  shift1 = v >> 1;
      default: shift1 = {v[WIDTH-1], v[WIDTH-1:1]};
    endcase
  endfunction

  // Shared adder; SLT uses the subtract path and corrects the sign with the overflow bit
  always_comb begin
    is_sub  = (op == OP_SUB) || (op == OP_SLT);
    b_eff   = is_sub ? ~src2 : src2;
    sum     = {1'b0, src1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    add_ovf = (src1[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != src1[WIDTH-1]);
    less    = sum[WIDTH-1] ^ add_ovf;
  end

  // Result and flags for the ops that complete at the accept edge
  always_comb begin
    imm_res = '0;
    imm_c   = 1'b0;
    imm_v   = 1'b0;
    case (op)
      OP_AND: imm_res = src1 & src2;
      OP_OR:  imm_res = src1 | src2;
      OP_NOR: imm_res = ~(src1 | src2);
      OP_ADD, OP_SUB: begin
        imm_res = sum[WIDTH-1:0];
        imm_c   = sum[WIDTH];
        imm_v   = add_ovf;
      end
      OP_SLT: imm_res = {{(WIDTH-1){1'b0}}, less};
      default: imm_res = '0;
    endcase
  end

  // Next multiply accumulator value for the current step
  always_comb begin
    acc_next = acc + (b_reg[0] ? a_reg : '0);
  end

  // Control FSM with registered outputs; the accept edge already performs the first
  // shift/multiply step so the total latency equals the step count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      acc      <= '0;
      cnt      <= '0;
      op_reg   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_SLL, OP_SRL, OP_SRA: begin
                if (amt == '0) begin
                  result   <= src1;
                  cout     <= 1'b0;
                  overflow <= 1'b0;
                  done     <= 1'b1;
                end else if (amt == SW'(1)) begin
                  result   <= shift1(op, src1);
                  cout     <= 1'b0;
                  overflow <= 1'b0;
                  done     <= 1'b1;
                end else begin
                  a_reg  <= shift1(op, src1);
                  cnt    <= amt - SW'(1);
                  op_reg <= op;
                  busy   <= 1'b1;
                  state  <= SHIFT;
                end
              end
              OP_MUL: begin
                acc   <= src2[0] ? src1 : '0;
                a_reg <= src1 << 1;
                b_reg <= src2 >> 1;
                cnt   <= SW'(WIDTH - 1);
                busy  <= 1'b1;
                state <= MUL;
              end
              default: begin
                result   <= imm_res;
                cout     <= imm_c;
                overflow <= imm_v;
                done     <= 1'b1;
              end
            endcase
          end
        end
        SHIFT: begin
          a_reg <= shift1(op_reg, a_reg);
          cnt   <= cnt - SW'(1);
          if (cnt == SW'(1)) begin
            result   <= shift1(op_reg, a_reg);
            cout     <= 1'b0;
            overflow <= 1'b0;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        MUL: begin
          acc   <= acc_next;
          a_reg <= a_reg << 1;
          b_reg <= b_reg >> 1;
          cnt   <= cnt - SW'(1);
          if (cnt == SW'(1)) begin
            result   <= acc_next;
            cout     <= 1'b0;
            overflow <= 1'b0;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the 32-bit datapath ALU.
- Accepts one operation per start/done handshake and registers all outputs.
- Keeps the existing single-cycle AND/OR/ADD/SUB/NOR/SLT encodings, and adds iterative shifts (one bit per cycle) and a shift-add multiply (one bit per cycle).
- Sits between the register-read stage and writeback; the controller stalls on `busy`.

## Interface
- `WIDTH`, default 32: datapath width. Must be a power of two, ≥ 4. `SW = $clog2(WIDTH)`.
- `clk`  input  1  system clock, rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request. Accepted on a rising edge when `busy` = 0.
- `src1`  input  WIDTH  operand A. Sampled only at accept.
- `src2`  input  WIDTH  operand B, or shift amount in `src2[SW-1:0]`. Sampled only at accept.
- `ALU_control`  input  4  opcode. Sampled only at accept.
- `busy`  output  1  multi-cycle operation in progress.
- `done`  output  1  one-cycle pulse: result and flags were just updated.
- `result`  output  WIDTH  registered result.
- `zero`  output  1  high when `result` == 0.
- `cout`  output  1  registered carry out.
- `overflow`  output  1  registered signed overflow.

## Operation
- Opcodes and results:
  - 0000: AND.
  - 0001: OR.
  - 0010: ADD.
  - 0110: SUB, computed as A + ~B + 1.
  - 1100: NOR.
  - 0111: SLT, signed. Result = {0…, A<B}, computed correctly even when A−B overflows.
  - 0011: SLL, A << s.
  - 0100: SRL, A >> s, zero fill.
  - 0101: SRA, A >>> s, sign fill.
  - 1000: MUL, low WIDTH bits of A×B, unsigned/signed-agnostic.
  - Any other code: result 0, single-cycle.
  - s = `src2[SW-1:0]`. Upper bits of `src2` are ignored for shifts.
- Flags:
  - `cout`: final carry of the adder for ADD/SUB. For SUB, 1 means no borrow. 0 for all other ops.
  - `overflow`: two's-complement overflow for ADD/SUB only. 0 otherwise.
  - `zero`: combinational from the `result` register, valid for every op.
- States:
  - IDLE: `busy` = 0. On accept, latch A, B and the opcode. Single-cycle ops, and shifts with s = 0, complete at the accept edge and stay in IDLE.
  - SHIFT: a counter is loaded with s. Each edge shifts A by one bit and decrements the counter. When the counter reaches 0, write the result, pulse `done`, and return to IDLE.
  - MUL: an accumulator is cleared and a counter loaded with WIDTH. Each edge adds A if B[0] = 1, then A <<= 1 and B >>= 1. When WIDTH steps are complete, write the result, pulse `done`, and return to IDLE.
- `result`/`cout`/`overflow` hold their last values until the next completion. Starting a new op does not clear them.
- `start` while `busy` = 1 is ignored, with no queueing. Operand changes during `busy` have no effect.
- `start` in the cycle `done` is high is accepted, because `busy` is already 0. This gives back-to-back issue.

## Timing
- Reset (async assert): `busy` = 0, `done` = 0, `result` = 0, `cout` = 0, `overflow` = 0, so `zero` = 1. State returns to IDLE.
  - Reset mid-operation aborts the op with no `done`.
  - The first accept is possible at the first rising edge after `rst_n` deasserts.
- Latency L, counted from accept edge k to `done` high following edge k+L−1:
  - Single-cycle ops: L = 1.
  - SLL/SRL/SRA: L = max(1, s).
  - MUL: L = WIDTH.
- `busy` is high for the L−1 cycles after edge k. It is never high when L = 1.
- `done` is high for exactly one cycle per accepted op. `result` is stable from that cycle onward.

## Test plan
- ADD `0x7FFFFFFF` + `0x00000001` -> `result` `0x80000000`, `overflow` 1, `cout` 0, `done` 1 cycle after accept, `busy` never high.
- SUB 5 − 5 -> `result` 0, `zero` 1, `cout` 1, `overflow` 0. Then SLT `0x80000000` vs 1 -> `result` 1, and SLT 1 vs `0xFFFFFFFF` -> `result` 0.
- SRA `0x80000000` with s = 4 -> `result` `0xF8000000` after L = 4. `busy` is high for 3 cycles. A `start`(ADD) pulsed during `busy` is ignored, with no extra `done`.
- MUL `0x0000FFFF` × `0x00010001` -> `result` `0xFFFFFFFF`, `done` 32 cycles after accept, `cout`/`overflow` 0. Repeat with WIDTH = 8: `0x0F` × `0x11` -> `0xFF`, L = 8.
- Back-to-back: assert `start`(OR `0xF0` | `0x0F`) in the `done` cycle of a MUL -> accepted, `result` `0xFF` one cycle later. SLL with s = 0 -> L = 1, `result` = A.
- Assert `rst_n` low at cycle 10 of a MUL -> all outputs go to reset values immediately with no `done`. After release, ADD 2 + 3 -> `result` 5 with L = 1.
